// File: rtl/updown_counter_bank.sv
// updown_counter_bank: a bank of independent, loadable up/down counters.
// Each channel can either wrap or saturate at its boundaries; this is fixed
// per instance by a parameter. Each channel reports:
//   - terminal-count decodes (at_max, at_min) taken from the count register,
//   - a one-cycle registered boundary event (bound_evt),
//   - a sticky boundary flag (bound_sticky) that firmware clears with clr_flags.
module updown_counter_bank #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int SATURATE = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [CHANNELS-1:0]         up,
  input  logic [CHANNELS-1:0]         down,
  input  logic [CHANNELS-1:0]         load,
  input  logic [CHANNELS*WIDTH-1:0]   load_data,
  input  logic [CHANNELS-1:0]         clr_flags,
  output logic [CHANNELS*WIDTH-1:0]   count,
  output logic [CHANNELS-1:0]         at_max,
  output logic [CHANNELS-1:0]         at_min,
  output logic [CHANNELS-1:0]         bound_evt,
  output logic [CHANNELS-1:0]         bound_sticky
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_MIN = '0;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             evt_q;
    logic             evt_d;
    logic             sticky_q;
    logic             inc_req;
    logic             dec_req;

    // up and down together cancel, so only a lone request moves the count.
    assign inc_req = up[i] & ~down[i];
    assign dec_req = down[i] & ~up[i];

    // Next-state selection: load > single-direction step > hold.
    always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      cnt_d = cnt_q;
      evt_d = 1'b0;
      if (load[i]) begin
        cnt_d = load_data[i*WIDTH +: WIDTH];
      end else if (inc_req) begin
        if (cnt_q == CNT_MAX) begin
          evt_d = 1'b1;
          if (SATURATE == 0) cnt_d = CNT_MIN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (dec_req) begin
        if (cnt_q == CNT_MIN) begin
          evt_d = 1'b1;
          if (SATURATE == 0) cnt_d = CNT_MAX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end

    // Channel state registers; reset is synchronous and overrides every
    // other input. When a new event and a clear arrive together, the set wins.
    always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so that every register samples the
      // pre-edge value of its neighbours, independent of statement order.
      if (reset) begin
        cnt_q    <= CNT_MIN;
        evt_q    <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        evt_q    <= evt_d;
        sticky_q <= evt_d | (sticky_q & ~clr_flags[i]);
      end
    end

    assign count[i*WIDTH +: WIDTH] = cnt_q;
    assign at_max[i]               = (cnt_q == CNT_MAX);
    assign at_min[i]               = (cnt_q == CNT_MIN);
    assign bound_evt[i]            = evt_q;
    assign bound_sticky[i]         = sticky_q;
  end

endmodule

// File: tb/tb_updown_counter_bank.sv
// Directed testbench for updown_counter_bank. There are two instances with
// the same inputs: u_wrap (SATURATE=0) and u_sat (SATURATE=1).
// All expected values below were computed by hand.
module tb_updown_counter_bank;

  localparam int W = 4;
  localparam int C = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [C-1:0]   up, down, load, clr_flags;
  logic [C*W-1:0] load_data;

  logic [C*W-1:0] w_count, s_count;
  logic [C-1:0]   w_at_max, w_at_min, w_evt, w_sticky;
  logic [C-1:0]   s_at_max, s_at_min, s_evt, s_sticky;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  updown_counter_bank #(.WIDTH(W), .CHANNELS(C), .SATURATE(0)) u_wrap (
    .clk(clk), .reset(reset), .up(up), .down(down), .load(load),
    .load_data(load_data), .clr_flags(clr_flags), .count(w_count),
    .at_max(w_at_max), .at_min(w_at_min), .bound_evt(w_evt),
    .bound_sticky(w_sticky)
  );

  updown_counter_bank #(.WIDTH(W), .CHANNELS(C), .SATURATE(1)) u_sat (
    .clk(clk), .reset(reset), .up(up), .down(down), .load(load),
    .load_data(load_data), .clr_flags(clr_flags), .count(s_count),
    .at_max(s_at_max), .at_min(s_at_min), .bound_evt(s_evt),
    .bound_sticky(s_sticky)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; up = '0; down = '0; load = '0; clr_flags = '0; load_data = '0;
    step(); step();
    reset = 1'b0;

    // Reset state.
    check("rst_w_count",  32'(w_count),  32'h00);
    check("rst_w_at_min", 32'(w_at_min), 32'h3);
    check("rst_w_at_max", 32'(w_at_max), 32'h0);
    check("rst_w_evt",    32'(w_evt),    32'h0);
    check("rst_w_sticky", 32'(w_sticky), 32'h0);
    check("rst_s_count",  32'(s_count),  32'h00);
    check("rst_s_sticky", 32'(s_sticky), 32'h0);

    // 1: three ups on channel 0.
    up = 2'b01;
    step(); check("t1_c1",  32'(w_count[3:0]), 32'h1);
    step(); check("t1_c2",  32'(w_count[3:0]), 32'h2);
    step(); check("t1_c3",  32'(w_count[3:0]), 32'h3);
    up = 2'b00;
    check("t1_ch1",       32'(w_count[7:4]), 32'h0);
    check("t1_at_min1",   32'(w_at_min[1]),  32'h1);
    check("t1_evt",       32'(w_evt),        32'h0);
    check("t1_s_c3",      32'(s_count[3:0]), 32'h3);

    // 2: wrap at max on channel 0.
    load = 2'b01; load_data = 8'h0E;
    step(); load = 2'b00;
    check("t2_load",      32'(w_count[3:0]), 32'hE);
    up = 2'b01;
    step();
    check("t2_F",         32'(w_count[3:0]), 32'hF);
    check("t2_F_evt",     32'(w_evt[0]),     32'h0);
    check("t2_F_atmax",   32'(w_at_max[0]),  32'h1);
    step();
    check("t2_wrap",      32'(w_count[3:0]), 32'h0);
    check("t2_wrap_evt",  32'(w_evt[0]),     32'h1);
    check("t2_sticky",    32'(w_sticky[0]),  32'h1);
    check("t2_s_hold",    32'(s_count[3:0]), 32'hF);
    check("t2_s_evt",     32'(s_evt[0]),     32'h1);
    up = 2'b00;
    step();
    check("t2_evt_drop",  32'(w_evt[0]),     32'h0);
    check("t2_sticky_hd", 32'(w_sticky[0]),  32'h1);

    // 3: wrap below zero on channel 1.
    down = 2'b10;
    step(); down = 2'b00;
    check("t3_count1",    32'(w_count[7:4]), 32'hF);
    check("t3_atmax1",    32'(w_at_max[1]),  32'h1);
    check("t3_evt1",      32'(w_evt[1]),     32'h1);
    check("t3_s_count1",  32'(s_count[7:4]), 32'h0);
    check("t3_s_evt1",    32'(s_evt[1]),     32'h1);
    step();
    check("t3_evt1_drop", 32'(w_evt[1]),     32'h0);
    check("t3_hold1",     32'(w_count[7:4]), 32'hF);

    // 4: saturate at max for three cycles, then at zero for two cycles.
    load = 2'b01; load_data = 8'h0F;
    step(); load = 2'b00;
    check("t4_load",      32'(s_count[3:0]), 32'hF);
    check("t4_load_evt",  32'(s_evt[0]),     32'h0);
    up = 2'b01;
    for (int k = 0; k < 3; k++) begin
      step();
      check("t4_sat_max",     32'(s_count[3:0]), 32'hF);
      check("t4_sat_max_evt", 32'(s_evt[0]),     32'h1);
    end
    up = 2'b00;
    step();
    check("t4_max_evt_drop", 32'(s_evt[0]), 32'h0);
    load = 2'b01; load_data = 8'h00;
    step(); load = 2'b00;
    down = 2'b01;
    for (int k = 0; k < 2; k++) begin
      step();
      check("t4_sat_min",     32'(s_count[3:0]), 32'h0);
      check("t4_sat_min_evt", 32'(s_evt[0]),     32'h1);
      check("t4_sat_atmin",   32'(s_at_min[0]),  32'h1);
    end
    down = 2'b00;
    step();
    check("t4_min_evt_drop", 32'(s_evt[0]), 32'h0);

    // 5: priority checks on channel 0.
    clr_flags = 2'b11;
    step(); clr_flags = 2'b00;
    check("t5_pre_clr",   32'(w_sticky),     32'h0);
    load = 2'b01; load_data = 8'h05;
    step(); load = 2'b00;
    up = 2'b01; down = 2'b01;
    step(); up = 2'b00; down = 2'b00;
    check("t5_cancel",     32'(w_count[3:0]), 32'h5);
    check("t5_cancel_evt", 32'(w_evt[0]),     32'h0);
    load = 2'b01; up = 2'b01; load_data = 8'h09;
    step(); load = 2'b00; up = 2'b00;
    check("t5_load_pri",  32'(w_count[3:0]), 32'h9);
    load = 2'b01; load_data = 8'h0F;
    step(); load = 2'b00;
    up = 2'b01; clr_flags = 2'b01;
    step(); up = 2'b00;
    check("t5_setclr_cnt",    32'(w_count[3:0]), 32'h0);
    check("t5_setclr_evt",    32'(w_evt[0]),     32'h1);
    check("t5_set_wins",      32'(w_sticky[0]),  32'h1);
    step(); clr_flags = 2'b00;
    check("t5_clr_alone",     32'(w_sticky[0]),  32'h0);
    check("t5_clr_evt",       32'(w_evt[0]),     32'h0);

    // 6: reset in the middle of counting.
    load = 2'b11; load_data = 8'hF7;
    step(); load = 2'b00;
    check("t6_load7",     32'(w_count[3:0]), 32'h7);
    down = 2'b10;
    step(); down = 2'b00;
    check("t6_evt_pre",   32'(w_evt[1]),     32'h0);
    up = 2'b01; reset = 1'b1;
    step(); reset = 1'b0;
    check("t6_rst_cnt",    32'(w_count),  32'h00);
    check("t6_rst_evt",    32'(w_evt),    32'h0);
    check("t6_rst_sticky", 32'(w_sticky), 32'h0);
    check("t6_rst_atmin",  32'(w_at_min), 32'h3);
    step();
    check("t6_resume1",   32'(w_count[3:0]), 32'h1);
    step();
    check("t6_resume2",   32'(w_count[3:0]), 32'h2);
    up = 2'b00;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/updown_counter_bank.md
Name: updown_counter_bank

Overview:
- Bank of CHANNELS independent, loadable up/down counters, each WIDTH bits wide.
- Each channel has a compile-time boundary mode: wrap-around or saturate.
- Each channel reports terminal-count flags, a one-cycle boundary event pulse and a sticky boundary flag.
- Used as the shared event/occupancy counter resource in the datapath. It replaces fixed-width single-direction counters.

Parameters:
- WIDTH, 4, bit width of each counter (≥2).
- CHANNELS, 2, number of independent counters (≥1).
- SATURATE, 0, 0 = wrap at boundaries; 1 = hold at boundaries.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- up  input  CHANNELS  per-channel increment request.
- down  input  CHANNELS  per-channel decrement request.
- load  input  CHANNELS  per-channel load strobe.
- load_data  input  CHANNELS*WIDTH  per-channel load values; channel i uses bits [i*WIDTH +: WIDTH].
- clr_flags  input  CHANNELS  per-channel sticky-flag clear.
- count  output  CHANNELS*WIDTH  per-channel count register, packed like load_data.
- at_max  output  CHANNELS  count[i] == 2^WIDTH-1, decoded from the register.
- at_min  output  CHANNELS  count[i] == 0, decoded from the register.
- bound_evt  output  CHANNELS  registered one-cycle pulse: boundary crossing/hit.
- bound_sticky  output  CHANNELS  sticky boundary flag.

Behaviour:
- All state changes happen on the rising edge of clk. Channels are fully independent; there is no cross-channel interaction.
- Reset (synchronous; reset is sampled only at the clock edge and has no asynchronous path): count=0, bound_evt=0, bound_sticky=0 for every channel.
  - Therefore at_min=1 and at_max=0 after reset.
  - Reset asserted mid-operation overrides every other input that cycle.
- Per-channel priority, highest first: reset > load > (up XOR down) > hold.
- load=1: count <= load_data slice on the next edge.
  - up and down are ignored that cycle.
  - bound_evt <= 0. The sticky flag is unaffected except by clr_flags.
- up=1 and down=1 together (no load): count holds, bound_evt <= 0. The requests cancel; neither direction has priority.
- up only:
  - count != max: count <= count+1 (modulo 2^WIDTH).
  - count == max, SATURATE=0: count <= 0, bound_evt <= 1.
  - count == max, SATURATE=1: count holds at max, bound_evt <= 1.
- down only:
  - count != 0: count <= count-1.
  - count == 0, SATURATE=0: count <= max, bound_evt <= 1.
  - count == 0, SATURATE=1: count holds at 0, bound_evt <= 1.
- Neither up nor down: count holds, bound_evt <= 0.
- Latency: count, bound_evt and bound_sticky update 1 cycle after the request. at_max and at_min are combinational decodes of the count register, so they are valid in the same cycle as count.
- bound_evt is high for exactly one cycle per boundary request. Repeated up requests at max in saturate mode give one pulse per cycle.
- bound_sticky:
  - Set on the same edge at which bound_evt is set.
  - Cleared by clr_flags=1.
  - If set and clear coincide in one cycle, set wins (bound_sticky=1).
- Arithmetic is unsigned WIDTH-bit with no hidden extra bits; max = 2^WIDTH-1.
- Undriven inputs must be 0; X handling is not required.

Test Plan (WIDTH=4, CHANNELS=2 unless noted):
1. Reset then 3 cycles of up[0] → count[0]=3, count[1]=0, at_min[1]=1, no bound_evt.
2. SATURATE=0:
   - load[0] with 4'hE, then up[0] for 2 cycles → count[0] goes E,F,0.
   - bound_evt[0]=1 only in the cycle count shows 0; bound_sticky[0]=1 afterwards.
3. SATURATE=0, from 0, down[1] for 1 cycle → count[1]=F, at_max[1]=1, bound_evt[1] pulses once.
4. SATURATE=1:
   - load 4'hF, then up for 3 cycles → count stays F, bound_evt high 3 cycles.
   - Then down from 0 for 2 cycles → count stays 0, bound_evt high 2 cycles.
5. Priority checks:
   - up=down=1 at count=5 → holds 5, no event.
   - load=1 with up=1, load_data=9 → count=9.
   - clr_flags asserted in the same cycle as a boundary event → bound_sticky=1.
   - clr_flags alone on the next cycle → bound_sticky=0.
6. Reset mid-count: count=7 with up held and reset=1 for 1 cycle → next cycle count=0 and flags=0; counting resumes 1,2,... after reset drops.
